// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes, sequencer FSM states and
// default multi-cycle latencies used by the divider and multiplier.
package alu_pkg;

    localparam int FUNCT_W    = 6;
    localparam int CNT_W      = 7;
    localparam int DIV_CYCLES = 32;
    localparam int MUL_CYCLES = 32;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_OUT   = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct classifier: single-cycle, multi-cycle or illegal,
// plus the RUN length for multi-cycle ops.
// Ports: funct_i in; is_single_o, is_multi_o, is_illegal_o, lat_o out.
module alu_funct_decode #(
    parameter int CNT_W      = 7,
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic [alu_pkg::FUNCT_W-1:0] funct_i,
    output logic                        is_single_o,
    output logic                        is_multi_o,
    output logic                        is_illegal_o,
    output logic [CNT_W-1:0]            lat_o
);
    import alu_pkg::*;

    always_comb begin
        is_single_o  = 1'b0;
        is_multi_o   = 1'b0;
        is_illegal_o = 1'b0;
        lat_o        = '0;
        unique case (funct_i)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT,
            F_SLL, F_MFHI, F_MFLO, F_OUT: begin
                is_single_o = 1'b1;
            end
            F_DIVU: begin
                is_multi_o = 1'b1;
                lat_o      = CNT_W'(DIV_CYCLES);
            end
            F_MULTU: begin
                is_multi_o = 1'b1;
                lat_o      = CNT_W'(MUL_CYCLES);
            end
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU op sequencer: issues funct codes, runs DIVU/MULTU for a
// fixed cycle count, then issues OUT with a HI/LO write strobe.
// Ports: clk, rst_n, funct, funct_valid, flush in; busy, ctrl_alu/sht/div/
// mux, hilo_we, done, illegal out.
module alu_op_sequencer #(
    parameter int FUNCT_W    = alu_pkg::FUNCT_W,
    parameter int DIV_CYCLES = alu_pkg::DIV_CYCLES,
    parameter int MUL_CYCLES = alu_pkg::MUL_CYCLES,
    parameter int CNT_W      = alu_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               funct_valid,
    input  logic               flush,
    output logic               busy,
    output logic [FUNCT_W-1:0] ctrl_alu,
    output logic [FUNCT_W-1:0] ctrl_sht,
    output logic [FUNCT_W-1:0] ctrl_div,
    output logic [FUNCT_W-1:0] ctrl_mux,
    output logic               hilo_we,
    output logic               done,
    output logic               illegal
);
    import alu_pkg::*;

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (FUNCT_W != alu_pkg::FUNCT_W) begin : g_bad_fw
        $error("FUNCT_W must match the package code width");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > CNT_MAX) begin : g_bad_div
        $error("DIV_CYCLES out of counter range");
    end
    if (MUL_CYCLES < 1 || MUL_CYCLES > CNT_MAX) begin : g_bad_mul
        $error("MUL_CYCLES out of counter range");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FUNCT_W-1:0] ctrl_q, ctrl_d;
    logic               done_q, done_d;
    logic               ill_q, ill_d;
    logic               hilo_q, hilo_d;

    logic               is_single;
    logic               is_multi;
    logic               is_illegal;
    logic [CNT_W-1:0]   lat;

    alu_funct_decode #(
        .CNT_W      (CNT_W),
        .DIV_CYCLES (DIV_CYCLES),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_dec (
        .funct_i      (funct),
        .is_single_o  (is_single),
        .is_multi_o   (is_multi),
        .is_illegal_o (is_illegal),
        .lat_o        (lat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            hilo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
            hilo_q  <= hilo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        hilo_d  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ctrl_d  = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_WB;
                    ctrl_d  = F_OUT;
                    done_d  = 1'b1;
                    hilo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // IDLE and WB both accept; WB outputs are already registered.
                state_d = S_IDLE;
                if (funct_valid && !flush) begin
                    unique case (1'b1)
                        is_single: begin
                            ctrl_d = funct;
                            done_d = 1'b1;
                        end
                        is_multi: begin
                            ctrl_d  = funct;
                            cnt_d   = lat - CNT_W'(1);
                            state_d = S_RUN;
                        end
                        is_illegal: begin
                            ill_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign ctrl_alu = ctrl_q;
    assign ctrl_sht = ctrl_q;
    assign ctrl_div = ctrl_q;
    assign ctrl_mux = ctrl_q;
    assign hilo_we  = hilo_q;
    assign done     = done_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_alu_op_sequencer;

    localparam int DIVN = 32;
    localparam int MULN = 4;

    localparam logic [5:0] C_AND   = 6'b100100;
    localparam logic [5:0] C_ADD   = 6'b100000;
    localparam logic [5:0] C_SUB   = 6'b100010;
    localparam logic [5:0] C_SLT   = 6'b101010;
    localparam logic [5:0] C_DIVU  = 6'b011011;
    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_OUT   = 6'b111111;
    localparam logic [5:0] C_BAD   = 6'b010101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] funct;
    logic       funct_valid;
    logic       flush;
    logic       busy;
    logic [5:0] ctrl_alu, ctrl_sht, ctrl_div, ctrl_mux;
    logic       hilo_we, done, illegal;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [5:0] m_ctrl;
    int         m_left;
    logic       m_done, m_ill, m_hilo;

    logic [5:0] singles[8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                               6'b101010, 6'b000000, 6'b010000, 6'b010010};

    alu_op_sequencer #(
        .DIV_CYCLES (DIVN),
        .MUL_CYCLES (MULN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .funct       (funct),
        .funct_valid (funct_valid),
        .flush       (flush),
        .busy        (busy),
        .ctrl_alu    (ctrl_alu),
        .ctrl_sht    (ctrl_sht),
        .ctrl_div    (ctrl_div),
        .ctrl_mux    (ctrl_mux),
        .hilo_we     (hilo_we),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // 0 = unknown, 1 = single-cycle, otherwise the busy length
    function automatic int op_len(input logic [5:0] f);
        foreach (singles[i]) if (singles[i] == f) return 1;
        if (f == C_DIVU) return DIVN;
        if (f == C_MULTU) return MULN;
        return 0;
    endfunction

    task automatic model(input logic r, input logic v,
                         input logic [5:0] f, input logic fl);
        int len;
        m_done = 1'b0;
        m_ill  = 1'b0;
        m_hilo = 1'b0;
        if (!r) begin
            m_ctrl = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            if (fl) begin
                m_left = 0;
                m_ctrl = '0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_ctrl = C_OUT;
                    m_hilo = 1'b1;
                    m_done = 1'b1;
                end
            end
        end else if (v && !fl) begin
            len = op_len(f);
            if (len == 0) begin
                m_ill = 1'b1;
            end else begin
                m_ctrl = f;
                if (len == 1) m_done = 1'b1;
                else m_left = len;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ctrl_alu", 32'(ctrl_alu), 32'(m_ctrl));
        chk("ctrl_sht", 32'(ctrl_sht), 32'(m_ctrl));
        chk("ctrl_div", 32'(ctrl_div), 32'(m_ctrl));
        chk("ctrl_mux", 32'(ctrl_mux), 32'(m_ctrl));
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("hilo_we", 32'(hilo_we), 32'(m_hilo));
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [5:0] f, input logic fl);
        rst_n       = r;
        funct_valid = v;
        funct       = f;
        flush       = fl;
        @(posedge clk);
        model(r, v, f, fl);
        #1;
        check_all();
    endtask

    initial begin
        logic [5:0] rf;
        logic       rr, rv, rfl;
        m_ctrl = '0;
        m_left = 0;
        m_done = 1'b0;
        m_ill  = 1'b0;
        m_hilo = 1'b0;
        rst_n = 1'b0;
        funct_valid = 1'b0;
        funct = '0;
        flush = 1'b0;

        // reset then idle
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, C_ADD, 1'b1);
        chk("rst_ctrl", 32'(ctrl_alu), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0);

        // back-to-back singles
        cyc(1'b1, 1'b1, C_ADD, 1'b0);
        chk("b2b_add", 32'(ctrl_alu), 32'(C_ADD));
        cyc(1'b1, 1'b1, C_SUB, 1'b0);
        chk("b2b_sub", 32'(ctrl_alu), 32'(C_SUB));
        cyc(1'b1, 1'b1, C_SLT, 1'b0);
        chk("b2b_slt", 32'(ctrl_alu), 32'(C_SLT));
        chk("b2b_done", 32'(done), 32'h1);

        // DIVU full run: busy cycles 1..32, WB at 33
        cyc(1'b1, 1'b1, C_DIVU, 1'b0);
        for (int k = 1; k <= 32; k++) cyc(1'b1, 1'b0, '0, 1'b0);
        chk("divu_wb_ctrl", 32'(ctrl_alu), 32'(C_OUT));
        chk("divu_wb_hilo", 32'(hilo_we), 32'h1);
        chk("divu_wb_busy", 32'(busy), 32'h0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("divu_after_hilo", 32'(hilo_we), 32'h0);

        // MULTU: WB at cycle 5
        cyc(1'b1, 1'b1, C_MULTU, 1'b0);
        for (int k = 1; k <= 4; k++) cyc(1'b1, 1'b0, '0, 1'b0);
        chk("multu_wb_hilo", 32'(hilo_we), 32'h1);
        chk("multu_wb_ctrl", 32'(ctrl_alu), 32'(C_OUT));
        cyc(1'b1, 1'b0, '0, 1'b0);

        // valid held through RUN, taken in WB
        cyc(1'b1, 1'b1, C_DIVU, 1'b0);
        for (int k = 1; k <= 33; k++) cyc(1'b1, k >= 5, C_AND, 1'b0);
        chk("wb_accept_ctrl", 32'(ctrl_alu), 32'(C_AND));
        chk("wb_accept_done", 32'(done), 32'h1);
        chk("wb_accept_hilo", 32'(hilo_we), 32'h0);
        cyc(1'b1, 1'b0, '0, 1'b0);

        // flush at cycle 10
        cyc(1'b1, 1'b1, C_DIVU, 1'b0);
        for (int k = 1; k <= 9; k++) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, C_ADD, 1'b1);
        chk("flush_ctrl", 32'(ctrl_alu), 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, '0, 1'b0);

        // reset at cycle 10, then watch for stray strobes
        cyc(1'b1, 1'b1, C_DIVU, 1'b0);
        for (int k = 1; k <= 9; k++) cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, C_MULTU, 1'b1);
        chk("rstmid_ctrl", 32'(ctrl_alu), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b0, '0, 1'b0);

        // illegal code leaves ctrl alone
        cyc(1'b1, 1'b1, C_SUB, 1'b0);
        cyc(1'b1, 1'b1, C_BAD, 1'b0);
        chk("ill_pulse", 32'(illegal), 32'h1);
        chk("ill_done", 32'(done), 32'h0);
        chk("ill_ctrl", 32'(ctrl_alu), 32'(C_SUB));
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk("ill_one_cycle", 32'(illegal), 32'h0);

        // random traffic
        for (int n = 0; n < 2500; n++) begin
            rr  = ($urandom_range(0, 199) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            rfl = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 9))
                0, 1:    rf = C_DIVU;
                2:       rf = C_MULTU;
                3:       rf = 6'($urandom);
                default: rf = singles[$urandom_range(0, 7)];
            endcase
            if (rf == C_OUT) rf = C_BAD;
            cyc(rr, rv, rf, rfl);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
